switch_debouncer: RTL and testbench

//   Front-end conditioning stage for slide switches and push buttons (SW/KEY) before they reach

---
 rtl/sw_io_pkg.sv | 5 +
 rtl/sync_2ff.sv | 19 +
 rtl/switch_debouncer.sv | 56 +++++
 tb/tb_switch_debouncer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/sw_io_pkg.sv
// sw_io_pkg: shared debounce lengths for simulation and the 50 MHz board build.
package sw_io_pkg;
  localparam int DEBOUNCE_CYCLES_SIM   = 16;
  localparam int DEBOUNCE_CYCLES_BOARD = 500000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser for asynchronous board inputs.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronise and debounce a switch; edge pulses built only with DEBOUNCE_EDGE_PULSE_EN.
module switch_debouncer
  import sw_io_pkg::*;
#(
  parameter  int STABLE_CYCLES = DEBOUNCE_CYCLES_SIM,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic noisy_in,
  output logic clean_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  logic s2, upd, clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sync_2ff u_sync (
    .clock(clock),
    .reset(reset),
    .d_i  (noisy_in),
    .q_o  (s2)
  );
  // any agreement with the current output restarts the stability window
  always_comb begin
    upd     = (s2 != clean_q) && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
    cnt_d   = (s2 == clean_q || upd) ? '0 : cnt_q + 1'b1;
    clean_d = upd ? s2 : clean_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end
  assign clean_out = clean_q;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q, fall_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= upd & s2;
      fall_q <= upd & ~s2;
    end
  end
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: scoreboard bench, STABLE_CYCLES=4, clean_out change events checked by cycle.
module tb_switch_debouncer;
  localparam int N = 4;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  typedef struct {
    int cyc;
    bit v;
  } exp_t;
  logic clock = 1'b0, reset = 1'b1, noisy_in = 1'b1;
  logic clean_out, rise_pulse, fall_pulse;
  int cyc = 0, checks = 0, errors = 0;
  logic prev = 1'b0;
  exp_t q[$];
  switch_debouncer #(.STABLE_CYCLES(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .noisy_in  (noisy_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic push_exp(input int at, input bit v);
    exp_t e;
    e.cyc = at;
    e.v   = v;
    q.push_back(e);
  endtask
  // change lands before edge cyc+1, so the output moves at edge cyc+N+2
  task automatic drive(input bit v, input bit expect_change);
    @(negedge clock);
    noisy_in = v;
    if (expect_change) push_exp(cyc + N + 2, v);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clock);
      n++;
    end
    repeat (6) @(posedge clock);
    chk("queue_drained", q.size(), 0);
  endtask
  task automatic chk_quiet(input string name);
    @(posedge clock);
    #1;
    chk({name, "_clean"}, int'(clean_out), 0);
    chk({name, "_rise"}, int'(rise_pulse), 0);
    chk({name, "_fall"}, int'(fall_pulse), 0);
  endtask
  always @(posedge clock) begin
    #1;
    if (clean_out !== prev || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event at edge %0d: clean=%b rise=%b fall=%b", cyc, clean_out, rise_pulse, fall_pulse);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_edge", cyc, e.cyc);
        chk("event_clean", int'(clean_out), int'(e.v));
        chk("event_rise", int'(rise_pulse), int'(PE && e.v));
        chk("event_fall", int'(fall_pulse), int'(PE && !e.v));
      end
      prev = clean_out;
    end
  end
  initial begin
    chk_quiet("reset_edge1");
    chk_quiet("reset_edge2");
    @(negedge clock);
    reset = 1'b0;
    push_exp(cyc + N + 2, 1'b1);
    chk_quiet("post_release");
    drain();
    drive(1'b0, 1'b1);
    drain();
    drive(1'b1, 1'b1);
    drain();
    drive(1'b0, 1'b1);
    drain();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drain();
    drive(1'b0, 1'b1);
    drain();
    drive(1'b1, 1'b0);
    repeat (2) @(negedge clock);
    drive(1'b0, 1'b0);
    drain();
    drive(1'b1, 1'b0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    chk_quiet("mid_count_reset");
    @(negedge clock);
    reset = 1'b0;
    push_exp(cyc + N + 2, 1'b1);
    drain();
    drive(1'b0, 1'b1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
